// File: rtl/delay_line_mc.sv
// Multi-channel circular-buffer delay line with a run-time programmable delay counted in samples.
// Define DLINE_DROP_CNT_EN to build the counter of samples suppressed during fill.
module delay_line_mc #(
   parameter int DATA_W        = 16,
   parameter int CHANNELS      = 4,
   parameter int DEPTH         = 1024,
   parameter int ADDR_W        = $clog2(DEPTH),
   parameter int DEFAULT_DELAY = 100
) (
   input  logic                       clk_a,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [CHANNELS*DATA_W-1:0] in_data,
   input  logic [CHANNELS-1:0]        ch_mask,
   input  logic                       cfg_load,
   input  logic [ADDR_W:0]            cfg_delay,
   output logic                       out_valid,
   output logic [CHANNELS*DATA_W-1:0] out_data,
   output logic                       running,
   output logic [ADDR_W:0]            cur_delay,
   output logic [15:0]                drop_cnt
);

   localparam int VEC_W       = CHANNELS * DATA_W;
   localparam int DEF_CLAMPED = (DEFAULT_DELAY < 1) ? 1 :
                                (DEFAULT_DELAY > DEPTH) ? DEPTH : DEFAULT_DELAY;
   localparam logic [ADDR_W:0]   DEPTH_V     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   DEF_DELAY_V = (ADDR_W+1)'(DEF_CLAMPED);
   localparam logic [ADDR_W:0]   ONE_V       = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(DEPTH - 1);

   typedef enum logic {FILL, RUN} state_t;

   function automatic logic [ADDR_W:0] clamp_delay(input logic [ADDR_W:0] req);
      if (req == '0)          return ONE_V;
      else if (req > DEPTH_V) return DEPTH_V;
      else                    return req;
   endfunction

   function automatic logic [VEC_W-1:0] mask_lanes(input logic [VEC_W-1:0] d,
                                                   input logic [CHANNELS-1:0] m);
      logic [VEC_W-1:0] r;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (m[c]) r[c*DATA_W +: DATA_W] = d[c*DATA_W +: DATA_W];
      end
      return r;
   endfunction

   logic [VEC_W-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       fill_cnt_q, fill_cnt_d;
   logic [ADDR_W:0]       cur_delay_q, cur_delay_d;
   logic                  out_valid_q, out_valid_d;
   logic [VEC_W-1:0]      out_data_q, out_data_d;
   logic signed [ADDR_W:0] rd_diff;
   logic [ADDR_W-1:0]     rd_addr;

   // Read address wraps back into [0, DEPTH) when the pointer difference goes negative.
   always_comb begin
      rd_diff = $signed({1'b0, wr_ptr_q}) - $signed(cur_delay_q);
      rd_addr = rd_diff[ADDR_W-1:0];
      if (rd_diff[ADDR_W]) rd_addr = rd_addr + DEPTH_V[ADDR_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      cur_delay_d = cur_delay_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;

      if (in_valid) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;

      if (cfg_load) begin
         // A sample arriving with the load is the first fill sample under the new delay.
         cur_delay_d = clamp_delay(cfg_delay);
         fill_cnt_d  = {{ADDR_W{1'b0}}, in_valid};
         state_d     = (in_valid && cur_delay_d == ONE_V) ? RUN : FILL;
      end else if (in_valid) begin
         if (fill_cnt_q < cur_delay_q) fill_cnt_d = fill_cnt_q + 1'b1;
         if (state_q == RUN) begin
            out_valid_d = 1'b1;
            out_data_d  = mask_lanes(mem[rd_addr], ch_mask);
         end else if (fill_cnt_q == cur_delay_q - ONE_V) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk_a or posedge reset_n) begin
      if (reset_n) begin
         state_q     <= FILL;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         cur_delay_q <= DEF_DELAY_V;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         cur_delay_q <= cur_delay_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Buffer storage is intentionally left out of reset; the read above sees the pre-write contents.
   always_ff @(posedge clk_a) begin
      if (in_valid) mem[wr_ptr_q] <= in_data;
   end

`ifdef DLINE_DROP_CNT_EN
   logic        fill_drop;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      fill_drop  = in_valid && (cfg_load || state_q == FILL);
      drop_cnt_d = drop_cnt_q;
      if (fill_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_a or posedge reset_n) begin
      if (reset_n) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'd0;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign running   = (state_q == RUN);
   assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: sample-history model feeding a scoreboard queue,
// a clamp table, and hand-written sequences for reprogramming, gaps, wrap and async reset.
module tb_delay_line_mc;

   localparam int DATA_W        = 16;
   localparam int CHANNELS      = 4;
   localparam int DEPTH         = 1024;
   localparam int ADDR_W        = 10;
   localparam int DEFAULT_DELAY = 100;
   localparam int DW            = DATA_W * CHANNELS;
`ifdef DLINE_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic              clk_a = 1'b0;
   logic              reset_n = 1'b1;
   logic              in_valid = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic [CHANNELS-1:0] ch_mask = '1;
   logic              cfg_load = 1'b0;
   logic [ADDR_W:0]   cfg_delay = '0;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              running;
   logic [ADDR_W:0]   cur_delay;
   logic [15:0]       drop_cnt;

   delay_line_mc #(
      .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .DEFAULT_DELAY(DEFAULT_DELAY)
   ) dut (
      .clk_a(clk_a), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .ch_mask(ch_mask), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
      .out_valid(out_valid), .out_data(out_data), .running(running),
      .cur_delay(cur_delay), .drop_cnt(drop_cnt)
   );

   always #5 clk_a = ~clk_a;

   typedef struct {
      logic [ADDR_W:0] req;
      logic [ADDR_W:0] exp_cur;
   } clamp_vec_t;

   clamp_vec_t    tbl [7];
   logic [DW-1:0] hist [$];
   logic [DW-1:0] sb_q [$];
   int            m_fill, m_delay, m_drop;
   int            checks = 0;
   int            errors = 0;

   function automatic int clampd(input int r);
      if (r == 0)     return 1;
      if (r > DEPTH)  return DEPTH;
      return r;
   endfunction

   function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] d, input logic [CHANNELS-1:0] m);
      logic [DW-1:0] r;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) if (m[c]) r[c*DATA_W +: DATA_W] = d[c*DATA_W +: DATA_W];
      return r;
   endfunction

   function automatic logic [DW-1:0] mkdata(input int k);
      logic [DW-1:0] r;
      for (int c = 0; c < CHANNELS; c++) r[c*DATA_W +: DATA_W] = 16'(k * 3 + c * 4099 + 1);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      sb_q.delete();
      m_fill  = 0;
      m_delay = DEFAULT_DELAY;
      m_drop  = 0;
   endtask

   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CHANNELS-1:0] m,
                        input logic cl, input logic [ADDR_W:0] cd);
      logic          exp_v;
      logic [DW-1:0] exp_d;
      in_valid  = iv;
      in_data   = d;
      ch_mask   = m;
      cfg_load  = cl;
      cfg_delay = cd;
      exp_v     = 1'b0;
      if (cl) begin
         m_delay = clampd(int'(cd));
         m_fill  = iv ? 1 : 0;
         if (iv) begin
            m_drop++;
            hist.push_back(d);
         end
      end else if (iv) begin
         if (m_fill >= m_delay) begin
            exp_v = 1'b1;
            sb_q.push_back(apply_mask(hist[hist.size() - m_delay], m));
         end else begin
            m_drop++;
         end
         m_fill++;
         hist.push_back(d);
      end
      @(posedge clk_a);
      #1;
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_data: got unexpected output %0h, expected none", out_data);
         end else begin
            exp_d = sb_q.pop_front();
            check("out_data", out_data, exp_d);
         end
      end else if (exp_v) begin
         void'(sb_q.pop_front());
      end
      check("running", {63'd0, running}, {63'd0, (m_fill >= m_delay)});
      check("cur_delay", 64'(cur_delay), 64'(m_delay));
      check("drop_cnt", 64'(drop_cnt), DROP_EN ? 64'(m_drop) : 64'd0);
      in_valid = 1'b0;
      cfg_load = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      cfg_load = 1'b0;
      reset_n  = 1'b1;
      @(posedge clk_a);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_running", {63'd0, running}, 64'd0);
      check("rst_cur_delay", 64'(cur_delay), 64'd100);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      model_reset();
      @(negedge clk_a);
      reset_n = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{11'd0,    11'd1};
      tbl[1] = '{11'd1,    11'd1};
      tbl[2] = '{11'd5,    11'd5};
      tbl[3] = '{11'd1024, 11'd1024};
      tbl[4] = '{11'd1025, 11'd1024};
      tbl[5] = '{11'd2000, 11'd1024};
      tbl[6] = '{11'd2047, 11'd1024};

      model_reset();
      do_reset();

      // Fill then run at the default delay, same value on every lane.
      for (int k = 0; k < 300; k++) cycle(1'b1, {4{16'(k)}}, 4'hF, 1'b0, '0);
      check("drop_after_fill", 64'(drop_cnt), DROP_EN ? 64'd100 : 64'd0);

      // Clamp table: load each request without a sample.
      for (int i = 0; i < 7; i++) begin
         cycle(1'b0, '0, 4'hF, 1'b1, tbl[i].req);
         check("tbl_cur_delay", 64'(cur_delay), 64'(tbl[i].exp_cur));
         check("tbl_running", {63'd0, running}, 64'd0);
      end

      // Delay 0 clamps to 1; then lane masking.
      cycle(1'b0, '0, 4'hF, 1'b1, 11'd0);
      for (int k = 0; k < 20; k++) cycle(1'b1, mkdata(k), (k < 6) ? 4'hF : 4'b0101, 1'b0, '0);

      // Gapped input at delay 5.
      cycle(1'b0, '0, 4'hF, 1'b1, 11'd5);
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, mkdata(1000 + k), 4'hF, 1'b0, '0);
         cycle(1'b0, '0, 4'hF, 1'b0, '0);
         cycle(1'b0, '0, 4'hF, 1'b0, '0);
      end

      // Reprogram mid-stream: D=10 then load D=3 with sample 50.
      cycle(1'b0, '0, 4'hF, 1'b1, 11'd10);
      for (int k = 0; k < 50; k++) cycle(1'b1, mkdata(2000 + k), 4'hF, 1'b0, '0);
      check("running_before_reload", {63'd0, running}, 64'd1);
      cycle(1'b1, mkdata(2050), 4'hF, 1'b1, 11'd3);
      check("running_drop", {63'd0, running}, 64'd0);
      check("reload_no_out", {63'd0, out_valid}, 64'd0);
      cycle(1'b1, mkdata(2051), 4'hF, 1'b0, '0);
      cycle(1'b1, mkdata(2052), 4'hF, 1'b0, '0);
      cycle(1'b1, mkdata(2053), 4'hF, 1'b0, '0);
      check("reload_first_out", out_data, mkdata(2050));
      for (int k = 54; k < 70; k++) cycle(1'b1, mkdata(2000 + k), 4'hF, 1'b0, '0);

      // Full-depth delay across two pointer wraps.
      cycle(1'b0, '0, 4'hF, 1'b1, 11'd2000);
      for (int k = 0; k < 3000; k++) cycle(1'b1, mkdata(5000 + k), 4'hF, 1'b0, '0);

      // Asynchronous reset between edges while running.
      check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      #2 reset_n = 1'b1;
      #1;
      check("async_out_valid", {63'd0, out_valid}, 64'd0);
      check("async_running", {63'd0, running}, 64'd0);
      check("async_drop_cnt", 64'(drop_cnt), 64'd0);
      check("async_out_data", out_data, 64'd0);
      check("async_cur_delay", 64'(cur_delay), 64'd100);
      model_reset();
      @(posedge clk_a);
      @(negedge clk_a);
      reset_n = 1'b0;
      for (int k = 0; k < 120; k++) cycle(1'b1, mkdata(9000 + k), 4'hF, 1'b0, '0);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_line_mc.md
# delay_line_mc

Parametrised multi-channel, sample-count delay line built on a circular buffer in a single clock domain. Every accepted input sample vector is written to the buffer. The vector accepted D samples earlier is emitted alongside it, where D is a run-time programmable delay. The block sits in the streaming datapath wherever a fixed, reprogrammable alignment delay between parallel channels is needed.

## Interface
Parameters:
- DATA_W, 16: bits per channel sample
- CHANNELS, 4: parallel channels sharing one write/read pointer pair
- DEPTH, 1024: buffer entries; maximum delay in samples; any value ≥ 2
- ADDR_W, $clog2(DEPTH): pointer width
- DEFAULT_DELAY, 100: delay loaded at reset; clamped like `cfg_delay`

Ports:
- clk_a  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-high reset (asserted = 1)
- in_valid  in  1  input sample vector present this cycle
- in_data  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- ch_mask  in  CHANNELS  1 = channel enabled; disabled channels output 0
- cfg_load  in  1  single-cycle pulse: apply `cfg_delay`
- cfg_delay  in  ADDR_W+1  requested delay in samples
- out_valid  out  1  delayed vector valid
- out_data  out  CHANNELS*DATA_W  delayed vector
- running  out  1  state == RUN
- cur_delay  out  ADDR_W+1  delay currently in force
- drop_cnt  out  16  samples suppressed during fill (see Configuration)

## Operation
- Storage: DEPTH × (CHANNELS*DATA_W) array. Write pointer `wr_ptr` advances by one per `in_valid` and wraps from DEPTH-1 to 0.
- Read address is `(wr_ptr - cur_delay) mod DEPTH`, computed in ADDR_W+1 bits. When the result is negative, add DEPTH.
- The read happens before the write in the same cycle. With D = DEPTH, the read returns the old entry at `wr_ptr`.
- Delay clamping:
  - `cfg_delay` = 0 is applied as 1.
  - `cfg_delay` > DEPTH is applied as DEPTH.
  - `cur_delay` always shows the clamped value.
- A fill counter `fill_cnt` (ADDR_W+1 bits) counts `in_valid` samples since the last reset or `cfg_load`. It saturates at `cur_delay`.
- States:
  - FILL (reset state): each `in_valid` increments `fill_cnt`. The sample is written but no output is produced. When `fill_cnt` reaches `cur_delay - 1` and `in_valid` = 1, the next state is RUN.
  - RUN: each `in_valid` produces an output vector. The state persists until reset or `cfg_load`.
- `cfg_load` (any state):
  - Latch the clamped delay, clear `fill_cnt`, go to FILL.
  - Buffer contents and `wr_ptr` are untouched.
  - If `in_valid` is high in the same cycle, that sample is written, counts as fill sample 1 under the new delay, and produces no output.
- Output masking: `out_data` lanes whose `ch_mask` bit is 0 are forced to 0. `ch_mask` is sampled in the same cycle as `in_valid`.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `running` = 0
  - `cur_delay` = clamped DEFAULT_DELAY
  - `drop_cnt` = 0, `wr_ptr` = 0, `fill_cnt` = 0
  - Buffer contents are not reset.
- Reset asserted mid-stream: all registers listed above return to their reset values immediately, asynchronously. The first sample after deassertion is treated as fill sample 1.

## Timing
- Latency is 1 cycle. `in_valid` at cycle t in RUN gives `out_valid` = 1 at t+1, with `out_data` = the sample accepted D samples earlier.
- `out_valid` is a registered copy of (`in_valid` && state == RUN && !`cfg_load`). It is 0 in every cycle without a qualifying input.
- Gaps in `in_valid` do not advance the pointers. The delay is counted in samples, not cycles.
- The first output after entering FILL comes from the (D+1)-th sample following the `cfg_load` or reset.
- `running` and `cur_delay` are registered. They update in the cycle after the causing edge.

## Configuration
- Macro: `DLINE_DROP_CNT_EN`.
- Defined:
  - `drop_cnt` increments by one for every `in_valid` accepted while in FILL, including a sample accepted in the same cycle as `cfg_load`.
  - `drop_cnt` saturates at 16'hFFFF and is cleared only by reset.
- Undefined:
  - `drop_cnt` is tied to 0 and no counter logic is generated.
  - All other behaviour is identical.

## Test plan
- Fill then run, DEFAULT_DELAY = 100: after reset, stream in_data = k on all 4 channels for k = 0..299, continuous `in_valid`.
  - `out_valid` first rises one cycle after sample 100 is accepted, with out_data = 0.
  - Each subsequent output equals k-100.
  - With the macro defined, `drop_cnt` = 100.
- Pointer wrap, D = 1024 (DEPTH): stream 3000 samples. Output for sample k equals k-1024 across both wrap points (1024 and 2048), with no glitch at the wrap.
- Gapped input, D = 5: drive `in_valid` every third cycle for 20 samples. Outputs equal k-5 and appear exactly one cycle after each qualifying input.
- Reprogram mid-stream: in RUN with D = 10, pulse `cfg_load` with `cfg_delay` = 3 together with `in_valid` on sample 50.
  - No output for samples 50–52.
  - Sample 53 outputs 50.
  - `running` drops the cycle after the `cfg_load` edge.
- Clamping and masking:
  - `cfg_delay` = 0 gives `cur_delay` = 1; the output is the previous sample.
  - `cfg_delay` = 2000 gives `cur_delay` = 1024.
  - `ch_mask` = 4'b0101 gives lanes 1 and 3 equal to 0 and lanes 0 and 2 correct.
- Async reset in RUN: assert `reset_n` between clock edges. `out_valid`, `running` and `drop_cnt` go to 0 before the next edge, and 100 fresh samples are suppressed after release.
